// File: rtl/lvds_rx_pkg.sv
// ---------------------------------------------------------------------------
// lvds_rx_pkg
// Shared definitions for the 2-lane LVDS frame receiver:
//   - FSM state encoding (IDLE, RECV, DROP)
//   - beats per byte and byte width
//   - layout of one output FIFO entry ({last, data})
// No ports; imported by lvds_rx_fifo and lvds_frame_rx.
// ---------------------------------------------------------------------------
package lvds_rx_pkg;

  localparam int BEATS_PER_BYTE = 4;
  localparam int BYTE_W         = 8;
  localparam int ENTRY_W        = BYTE_W + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RECV = 2'd1,
    DROP = 2'd2
  } rx_state_e;

  typedef struct packed {
    logic              last;
    logic [BYTE_W-1:0] data;
  } rx_entry_t;

endpackage

// File: rtl/lvds_rx_fifo.sv
// ---------------------------------------------------------------------------
// lvds_rx_fifo
// Synchronous first-word-fall-through FIFO for the LVDS receiver output.
// The head entry is presented combinationally from storage whenever the FIFO
// is not empty, so data is visible the cycle after it is written.
// A write into a full FIFO is accepted only if a read happens on the same
// edge; otherwise it is ignored (the caller flags the overflow).
// Ports:
//   clk      in   capture clock, posedge
//   rst      in   synchronous active-high reset (empties the FIFO)
//   wr_en    in   write request
//   wr_data  in   WIDTH-bit entry to write
//   rd_en    in   pop the head entry (ignored when empty)
//   rd_data  out  head entry (valid while !empty)
//   full     out  FIFO holds DEPTH entries
//   empty    out  FIFO holds no entries
// Parameters: DEPTH (power of 2, >=2), WIDTH.
// ---------------------------------------------------------------------------
module lvds_rx_fifo
  import lvds_rx_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int WIDTH = ENTRY_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_wr;
  logic             do_rd;

  assign empty = (count == '0);
  assign full  = (count == (AW+1)'(DEPTH));
  assign do_rd = rd_en & ~empty;
  // A pop on the same edge frees a slot, so a full FIFO still takes the write.
  assign do_wr = wr_en & (~full | do_rd);

  assign rd_data = mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + AW'(1);
      if (do_rd) rd_ptr <= rd_ptr + AW'(1);
      count <= count + (AW+1)'(do_wr) - (AW+1)'(do_rd);
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/lvds_frame_rx.sv
// ---------------------------------------------------------------------------
// lvds_frame_rx
// Receive side of the 2-lane LVDS capture path. While lvds_flag is high each
// posedge is one beat; four beats rebuild one byte (lane 0 carries bits 0..3,
// lane 1 carries bits 4..7, one bit of each per beat). Completed bytes are
// pushed with a last marker into a small FWFT output FIFO. The frame length is
// checked when the flag falls.
// Ports:
//   clk         in   capture clock, posedge
//   rst         in   synchronous active-high reset
//   lvds_data0  in   lane 0 (bit j of the byte on beat j)
//   lvds_data1  in   lane 1 (bit j+4 of the byte on beat j)
//   lvds_flag   in   frame enable, high for the whole frame burst
//   m_data      out  output byte
//   m_last      out  final byte of a correct-length frame
//   m_valid     out  output byte valid
//   m_ready     in   downstream accept (transfer = m_valid & m_ready)
//   len_err     out  one-cycle pulse: frame short/long or ended mid-byte
//   ovf         out  sticky: a byte was dropped because the FIFO was full
// Optional (macro LVDS_RX_STATS_EN):
//   frame_cnt   out  number of correct frames, wrapping
//   err_cnt     out  number of len_err pulses, wrapping
// ---------------------------------------------------------------------------
module lvds_frame_rx
  import lvds_rx_pkg::*;
#(
  parameter int FRAME_LEN = 896,
  parameter int OUT_DEPTH = 8,
  parameter int CNT_W     = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              lvds_data0,
  input  logic              lvds_data1,
  input  logic              lvds_flag,
  output logic [BYTE_W-1:0] m_data,
  output logic              m_last,
  output logic              m_valid,
  input  logic              m_ready,
  output logic              len_err,
  output logic              ovf
`ifdef LVDS_RX_STATS_EN
  ,
  output logic [CNT_W-1:0]  frame_cnt,
  output logic [CNT_W-1:0]  err_cnt
`endif
);

  localparam logic [CNT_W-1:0] LEN_C    = CNT_W'(FRAME_LEN);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FRAME_LEN - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [1:0]       LAST_BEAT = 2'(BEATS_PER_BYTE - 1);

  rx_state_e         state;
  logic [1:0]        beat_cnt;
  logic [CNT_W-1:0]  byte_cnt;
  logic [BYTE_W-1:0] sr;
  logic              wr_pend;
  logic              wr_last;

  logic              frame_end;
  logic              frame_bad;
  logic              fifo_full;
  logic              fifo_empty;
  logic              rd_en;
  rx_entry_t         wr_entry;
  rx_entry_t         rd_entry;

  // First edge with the flag low while a frame is open closes it.
  assign frame_end = (state != IDLE) && !lvds_flag;
  assign frame_bad = (byte_cnt != LEN_C) || (beat_cnt != 2'd0) || (state == DROP);

  // Sampler, FSM and counters. A completed byte is only flagged here
  // (wr_pend); the FIFO captures sr on the following edge, before the
  // next beat's non-blocking update of sr can land.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      beat_cnt <= '0;
      byte_cnt <= '0;
      sr       <= '0;
      wr_pend  <= 1'b0;
      wr_last  <= 1'b0;
      len_err  <= 1'b0;
    end else begin
      wr_pend <= 1'b0;
      len_err <= 1'b0;
      if (frame_end) begin
        len_err  <= frame_bad;
        state    <= IDLE;
        beat_cnt <= '0;
        byte_cnt <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (lvds_flag) begin
              state    <= RECV;
              sr[0]    <= lvds_data0;
              sr[4]    <= lvds_data1;
              beat_cnt <= 2'd1;
              byte_cnt <= '0;
            end
          end
          RECV: begin
            if (byte_cnt == LEN_C) begin
              // Frame already complete but flag still high: overlong frame.
              state    <= DROP;
              beat_cnt <= beat_cnt + 2'd1;
            end else begin
              sr[{1'b0, beat_cnt}] <= lvds_data0;
              sr[{1'b1, beat_cnt}] <= lvds_data1;
              beat_cnt <= beat_cnt + 2'd1;
              if (beat_cnt == LAST_BEAT) begin
                wr_pend  <= 1'b1;
                wr_last  <= (byte_cnt == LAST_IDX);
                byte_cnt <= byte_cnt + CNT_W'(1);
              end
            end
          end
          DROP: begin
            beat_cnt <= beat_cnt + 2'd1;
            if (beat_cnt == LAST_BEAT && byte_cnt != CNT_MAX)
              byte_cnt <= byte_cnt + CNT_W'(1);
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign wr_entry.last = wr_last;
  assign wr_entry.data = sr;

  assign rd_en = m_valid & m_ready;

  lvds_rx_fifo #(
    .DEPTH (OUT_DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_pend),
    .wr_data (wr_entry),
    .rd_en   (rd_en),
    .rd_data (rd_entry),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign m_valid = ~fifo_empty;
  assign m_data  = rd_entry.data;
  assign m_last  = rd_entry.last;

  // A write is lost only when the FIFO is full and not being popped.
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf <= 1'b0;
    end else if (wr_pend && fifo_full && !rd_en) begin
      ovf <= 1'b1;
    end
  end

`ifdef LVDS_RX_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      frame_cnt <= '0;
      err_cnt   <= '0;
    end else if (frame_end) begin
      if (frame_bad) err_cnt   <= err_cnt + CNT_W'(1);
      else           frame_cnt <= frame_cnt + CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_lvds_frame_rx.sv
// ---------------------------------------------------------------------------
// tb_lvds_frame_rx
// Scoreboard bench for lvds_frame_rx. A frame is described as a list of
// bytes plus trailing partial beats; the reference model turns that list into
// the expected output entries ({last, data}) and the expected error outcome.
// A monitor pops and compares on every output transfer.
// ---------------------------------------------------------------------------
module tb_lvds_frame_rx;

  localparam int FRAME_LEN = 896;
  localparam int OUT_DEPTH = 8;
  localparam int CNT_W     = 16;
  localparam int KEEP_ALL  = 1 << 30;

  logic       clk;
  logic       rst;
  logic       lvds_data0;
  logic       lvds_data1;
  logic       lvds_flag;
  logic [7:0] m_data;
  logic       m_last;
  logic       m_valid;
  logic       m_ready;
  logic       len_err;
  logic       ovf;
`ifdef LVDS_RX_STATS_EN
  logic [CNT_W-1:0] frame_cnt;
  logic [CNT_W-1:0] err_cnt;
`endif

  int checks = 0;
  int errors = 0;
  int errSeen = 0;
  int errExpTotal = 0;
  int goodSince = 0;
  int badSince = 0;
  int readyMode = 0;

  logic [7:0] frameBytes[$];
  logic [8:0] expQ[$];

  lvds_frame_rx #(
    .FRAME_LEN (FRAME_LEN),
    .OUT_DEPTH (OUT_DEPTH),
    .CNT_W     (CNT_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .lvds_data0 (lvds_data0),
    .lvds_data1 (lvds_data1),
    .lvds_flag  (lvds_flag),
    .m_data     (m_data),
    .m_last     (m_last),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .len_err    (len_err),
    .ovf        (ovf)
`ifdef LVDS_RX_STATS_EN
    ,
    .frame_cnt  (frame_cnt),
    .err_cnt    (err_cnt)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #3000000;
    $display("[TB] FAIL watchdog timeout");
    $fatal(1, "[TB] simulation did not finish");
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: bytes beyond FRAME_LEN are discarded, the byte at
  // position FRAME_LEN carries last, and only 'keep' leading bytes survive
  // to the output (FIFO overflow or flush). Any deviation from exactly
  // FRAME_LEN whole bytes is a length error.
  function automatic bit modelFrame(input int extraBeats, input int keep);
    int n;
    int acc;
    bit bad;
    n   = frameBytes.size();
    acc = (n < FRAME_LEN) ? n : FRAME_LEN;
    for (int i = 0; i < acc && i < keep; i++)
      expQ.push_back({(i == FRAME_LEN - 1), frameBytes[i]});
    bad = (n != FRAME_LEN) || (extraBeats != 0);
    if (bad) begin
      errExpTotal++;
      badSince++;
    end else begin
      goodSince++;
    end
    return bad;
  endfunction

  function automatic void fillSeq(input int first, input int n);
    frameBytes.delete();
    for (int i = 0; i < n; i++) frameBytes.push_back(8'((first + i) & 255));
  endfunction

  function automatic void fillRand(input int n);
    frameBytes.delete();
    for (int i = 0; i < n; i++) frameBytes.push_back(8'($urandom_range(0, 255)));
  endfunction

  // Drives the current frameBytes nibble-serially, then extra beats, then
  // lowers the flag and checks len_err on the fall edge.
  task automatic applyStimulus(input int extraBeats, input bit expErr, input bit latChk);
    logic [7:0] b;
    for (int i = 0; i < frameBytes.size(); i++) begin
      b = frameBytes[i];
      for (int j = 0; j < 4; j++) begin
        lvds_flag  = 1'b1;
        lvds_data0 = b[j];
        lvds_data1 = b[j+4];
        @(posedge clk); #1;
        if (latChk && i == 0 && j == 3) checkOutput("valid_1cyc_after_beat3", 32'(m_valid), 32'd0);
        if (latChk && i == 1 && j == 0) checkOutput("valid_2cyc_after_beat3", 32'(m_valid), 32'd1);
      end
    end
    for (int k = 0; k < extraBeats; k++) begin
      lvds_flag  = 1'b1;
      lvds_data0 = 1'($urandom_range(0, 1));
      lvds_data1 = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
    end
    lvds_flag  = 1'b0;
    lvds_data0 = 1'b0;
    lvds_data1 = 1'b0;
    @(posedge clk); #1;
    checkOutput("len_err_at_fall", 32'(len_err), 32'(expErr));
  endtask

  task automatic idle(input int n);
    lvds_flag = 1'b0;
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic setReady(input int mode);
    readyMode = mode;
    @(posedge clk); #1;
    @(posedge clk); #1;
  endtask

  task automatic doReset();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    goodSince = 0;
    badSince  = 0;
  endtask

  task automatic waitDrain();
    int k;
    k = 0;
    while ((expQ.size() != 0 || m_valid) && k < 3000) begin
      @(posedge clk); #1;
      k++;
    end
    checkOutput("drain_remaining", 32'(expQ.size()), 32'd0);
  endtask

  // Downstream ready: always, never, or random with at most three low
  // cycles in a row so the FIFO cannot fill at one byte per four cycles.
  initial begin
    int lowRun;
    lowRun  = 0;
    m_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (readyMode == 0) m_ready = 1'b1;
      else if (readyMode == 1) m_ready = 1'b0;
      else if (lowRun >= 3) begin
        m_ready = 1'b1;
        lowRun  = 0;
      end else begin
        m_ready = 1'($urandom_range(0, 1));
        lowRun  = m_ready ? 0 : lowRun + 1;
      end
    end
  end

  // Monitor: every transfer must match the head of the expected queue.
  initial begin
    logic [8:0] exp;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (len_err) errSeen++;
        if (m_valid && m_ready) begin
          if (expQ.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL unexpected_byte got %0h expected none at %0t", {m_last, m_data}, $time);
          end else begin
            exp = expQ.pop_front();
            checkOutput("out_entry", 32'({m_last, m_data}), 32'(exp));
          end
        end
      end
    end
  end

  initial begin
    bit e;
    int n;
    int extra;
    rst = 1'b1;
    lvds_flag = 1'b0;
    lvds_data0 = 1'b0;
    lvds_data1 = 1'b0;
    readyMode = 0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    $display("[TB] reset and idle");
    idle(100);
    checkOutput("idle_m_valid", 32'(m_valid), 32'd0);
    checkOutput("idle_len_err_seen", 32'(errSeen), 32'd0);
    checkOutput("idle_ovf", 32'(ovf), 32'd0);

    $display("[TB] single correct frame");
    fillSeq(1, FRAME_LEN);
    e = modelFrame(0, KEEP_ALL);
    applyStimulus(0, e, 1'b1);
    waitDrain();
    checkOutput("frame1_ovf", 32'(ovf), 32'd0);

    $display("[TB] back-to-back frames");
    fillSeq(1, FRAME_LEN);
    e = modelFrame(0, KEEP_ALL);
    applyStimulus(0, e, 1'b0);
    idle(99);
    fillSeq(FRAME_LEN + 1, FRAME_LEN);
    e = modelFrame(0, KEEP_ALL);
    applyStimulus(0, e, 1'b0);
    waitDrain();

    $display("[TB] short frame with partial byte");
    fillSeq(1, 10);
    e = modelFrame(2, KEEP_ALL);
    applyStimulus(2, e, 1'b0);
    idle(5);
    waitDrain();

    $display("[TB] long frame");
    fillSeq(1, 900);
    e = modelFrame(0, KEEP_ALL);
    applyStimulus(0, e, 1'b0);
    idle(5);
    waitDrain();
    checkOutput("long_ovf", 32'(ovf), 32'd0);

    $display("[TB] random frames, random ready");
    readyMode = 2;
    for (int f = 0; f < 14; f++) begin
      n = $urandom_range(1, 20);
      extra = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
      fillRand(n);
      e = modelFrame(extra, KEEP_ALL);
      applyStimulus(extra, e, 1'b0);
      idle($urandom_range(0, 3));
    end
    readyMode = 0;
    waitDrain();
    checkOutput("random_ovf", 32'(ovf), 32'd0);

    $display("[TB] downstream stalled for a whole frame");
    setReady(1);
    fillSeq(1, FRAME_LEN);
    e = modelFrame(0, OUT_DEPTH);
    applyStimulus(0, e, 1'b0);
    checkOutput("stall_ovf_set", 32'(ovf), 32'd1);
    checkOutput("stall_held_valid", 32'(m_valid), 32'd1);
    readyMode = 0;
    waitDrain();
    checkOutput("stall_ovf_sticky", 32'(ovf), 32'd1);

    $display("[TB] reset flushes FIFO and clears ovf");
    setReady(1);
    fillSeq(16, 3);
    e = modelFrame(0, 0);
    applyStimulus(0, e, 1'b0);
    idle(3);
    checkOutput("preflush_valid", 32'(m_valid), 32'd1);
    doReset();
    checkOutput("flush_valid", 32'(m_valid), 32'd0);
    checkOutput("flush_ovf", 32'(ovf), 32'd0);
    readyMode = 0;
    idle(5);

    $display("[TB] reset in the middle of a frame");
    setReady(1);
    for (int k = 0; k < 24; k++) begin
      lvds_flag  = 1'b1;
      lvds_data0 = 1'($urandom_range(0, 1));
      lvds_data1 = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
    end
    doReset();
    readyMode = 0;
    fillSeq(7, FRAME_LEN);
    e = modelFrame(0, KEEP_ALL);
    applyStimulus(0, e, 1'b0);
    idle(5);
    waitDrain();

    checkOutput("len_err_pulses", 32'(errSeen), 32'(errExpTotal));
`ifdef LVDS_RX_STATS_EN
    checkOutput("frame_cnt", 32'(frame_cnt), 32'(goodSince));
    checkOutput("err_cnt", 32'(err_cnt), 32'(badSince));
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
